c2h_pkt_framer: RTL and testbench

C2H_PKT_FRAMER -- requirements
Module: c2h_pkt_framer

---
 rtl/c2h_pkt_framer.sv | 159 +++++++++++++++
 tb/tb_c2h_pkt_framer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_pkt_framer.sv
// C2H packet framer: first-word-fall-through buffer from the app stream to the XDMA C2H
// channel. It splits packets at PKT_BEATS beats and raises one interrupt per emitted packet.
module c2h_pkt_framer #(
    parameter int TCQ             = 1,
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int PKT_BEATS       = 32
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [BYTE_BIT_ENABLE-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_c2h_tdata,
    output logic [BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
    output logic                       m_axis_c2h_tlast,
    output logic                       m_axis_c2h_tvalid,
    input  logic                       m_axis_c2h_tready,
    output logic                       irq_req,
    input  logic                       irq_ack,
    output logic [15:0]                pkt_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(PKT_BEATS);
    localparam int unsigned EW = DATA_WIDTH + BYTE_BIT_ENABLE + 1;

    // Registered outputs are modelled with zero delay, so TCQ only takes part in this check.
    if (TCQ < 0 || FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PKT_BEATS < 2)
    begin : g_bad_params
        $error("c2h_pkt_framer: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_GAP  = 2'd2
    } irq_state_t;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          head_last;
    logic [EW-1:0] head_nxt;
    logic [BW-1:0] beat_cnt, beat_cnt_nxt;
    logic          push, pop, pkt_done;
    logic          tlast_nxt, tvalid_nxt, tready_nxt;
    logic [15:0]   pkt_count_nxt;
    irq_state_t    irq_state, irq_state_nxt;
    logic [7:0]    irq_pend, irq_pend_nxt;

    // Buffer bookkeeping and the next head entry presented on the output registers.
    always_comb begin
        push          = s_axis_tvalid && s_axis_tready;
        pop           = m_axis_c2h_tvalid && m_axis_c2h_tready;
        pkt_done      = pop && m_axis_c2h_tlast;
        wr_ptr_nxt    = wr_ptr + AW'(push);
        rd_ptr_nxt    = rd_ptr + AW'(pop);
        count_nxt     = count + CW'(push) - CW'(pop);
        pkt_count_nxt = pkt_count + 16'(pkt_done);
        beat_cnt_nxt  = beat_cnt;
        if (pop) begin
            beat_cnt_nxt = m_axis_c2h_tlast ? '0 : beat_cnt + BW'(1);
        end
        // A beat entering an empty buffer bypasses the array so it is visible next cycle.
        if (count_nxt == '0) begin
            head_nxt = {head_last, m_axis_c2h_tkeep, m_axis_c2h_tdata};
        end else if (push && count == CW'(pop)) begin
            head_nxt = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
        tvalid_nxt = (count_nxt != '0);
        tready_nxt = (count_nxt != CW'(FIFO_DEPTH));
        tlast_nxt  = tvalid_nxt && (head_nxt[EW-1] || beat_cnt_nxt == BW'(PKT_BEATS - 1));
    end

    always_ff @(posedge user_clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            beat_cnt          <= '0;
            head_last         <= 1'b0;
            s_axis_tready     <= 1'b0;
            m_axis_c2h_tdata  <= '0;
            m_axis_c2h_tkeep  <= '0;
            m_axis_c2h_tlast  <= 1'b0;
            m_axis_c2h_tvalid <= 1'b0;
            pkt_count         <= '0;
        end else begin
            wr_ptr            <= wr_ptr_nxt;
            rd_ptr            <= rd_ptr_nxt;
            count             <= count_nxt;
            beat_cnt          <= beat_cnt_nxt;
            head_last         <= head_nxt[EW-1];
            s_axis_tready     <= tready_nxt;
            m_axis_c2h_tdata  <= head_nxt[DATA_WIDTH-1:0];
            m_axis_c2h_tkeep  <= head_nxt[DATA_WIDTH +: BYTE_BIT_ENABLE];
            m_axis_c2h_tlast  <= tlast_nxt;
            m_axis_c2h_tvalid <= tvalid_nxt;
            pkt_count         <= pkt_count_nxt;
        end
    end

    // Interrupt sequencing: completions that arrive during a request are queued in irq_pend.
    always_comb begin
        irq_state_nxt = irq_state;
        irq_pend_nxt  = irq_pend;
        case (irq_state)
            IRQ_IDLE: begin
                if (pkt_done) begin
                    irq_state_nxt = IRQ_REQ;
                end else if (irq_pend != 8'd0) begin
                    irq_state_nxt = IRQ_REQ;
                    irq_pend_nxt  = irq_pend - 8'd1;
                end
            end
            IRQ_REQ: begin
                if (pkt_done && irq_pend != 8'hFF) begin
                    irq_pend_nxt = irq_pend + 8'd1;
                end
                if (irq_ack) begin
                    irq_state_nxt = IRQ_GAP;
                end
            end
            IRQ_GAP: begin
                if (pkt_done && irq_pend != 8'hFF) begin
                    irq_pend_nxt = irq_pend + 8'd1;
                end
                irq_state_nxt = IRQ_IDLE;
            end
            default: irq_state_nxt = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            irq_state <= IRQ_IDLE;
            irq_pend  <= '0;
            irq_req   <= 1'b0;
        end else begin
            irq_state <= irq_state_nxt;
            irq_pend  <= irq_pend_nxt;
            irq_req   <= (irq_state_nxt == IRQ_REQ);
        end
    end

endmodule

// File: tb/tb_c2h_pkt_framer.sv
// Bench for c2h_pkt_framer: random beats scored against a queue model of the buffer,
// with packet splitting, counting and interrupt handshakes predicted from the framing rules.
module tb_c2h_pkt_framer;

    localparam int unsigned DW    = 128;
    localparam int unsigned KW    = DW / 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned PB    = 32;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          user_clk;
    logic          user_rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_c2h_tdata;
    logic [KW-1:0] m_axis_c2h_tkeep;
    logic          m_axis_c2h_tlast;
    logic          m_axis_c2h_tvalid;
    logic          m_axis_c2h_tready;
    logic          irq_req;
    logic          irq_ack;
    logic [15:0]   pkt_count;

    c2h_pkt_framer #(
        .TCQ(1), .DATA_WIDTH(DW), .BYTE_BIT_ENABLE(KW), .FIFO_DEPTH(DEPTH), .PKT_BEATS(PB)
    ) dut (
        .user_clk(user_clk), .user_rst(user_rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_c2h_tdata(m_axis_c2h_tdata), .m_axis_c2h_tkeep(m_axis_c2h_tkeep),
        .m_axis_c2h_tlast(m_axis_c2h_tlast), .m_axis_c2h_tvalid(m_axis_c2h_tvalid),
        .m_axis_c2h_tready(m_axis_c2h_tready),
        .irq_req(irq_req), .irq_ack(irq_ack), .pkt_count(pkt_count)
    );

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    beat_t       src_q[$];
    beat_t       exp_q[$];
    int          last_pos[$];
    int          checks = 0;
    int          errors = 0;
    int          valid_pct = 100;
    int          ready_pct = 100;
    int          out_idx = 0;
    int          accepted = 0;
    int          exp_pkt_beats = 0;
    logic [15:0] exp_pkt_count = '0;
    logic        stall_prev = 1'b0;
    beat_t       held;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_beats(input int n, input int last_every, input bit last_final,
                             input int last_pct);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = ($urandom_range(7) == 0) ? '0 : KW'($urandom);
            b.last = (last_every > 0 && (i + 1) % last_every == 0) ||
                     (last_final && i == n - 1) ||
                     (int'($urandom_range(99)) < last_pct);
            src_q.push_back(b);
        end
    endtask

    // Asynchronous reset entered mid-cycle; the model forgets everything in flight.
    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        irq_ack       = 1'b0;
        user_rst      = 1'b1;
        #1;
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_c2h_tvalid, 0);
        chk("rst_m_tlast", m_axis_c2h_tlast, 0);
        chk("rst_m_tdata", m_axis_c2h_tdata, 0);
        chk("rst_m_tkeep", m_axis_c2h_tkeep, 0);
        chk("rst_irq_req", irq_req, 0);
        chk("rst_pkt_count", pkt_count, 0);
        @(posedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        last_pos.delete();
        out_idx       = 0;
        accepted      = 0;
        exp_pkt_beats = 0;
        exp_pkt_count = '0;
        stall_prev    = 1'b0;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("tready_after_rst", s_axis_tready, 1);
    endtask

    // One clock: score the handshakes the coming edge will perform, then drive new inputs.
    task automatic cycle();
        logic  in_fire, out_fire, exp_last;
        beat_t eb;
        chk("m_tvalid", m_axis_c2h_tvalid, exp_q.size() != 0);
        chk("s_tready", s_axis_tready, exp_q.size() < DEPTH);
        if (stall_prev) begin
            chk("stall_tdata", m_axis_c2h_tdata, held.data);
            chk("stall_tkeep", m_axis_c2h_tkeep, held.keep);
            chk("stall_tlast", m_axis_c2h_tlast, held.last);
        end
        in_fire  = s_axis_tvalid && s_axis_tready;
        out_fire = m_axis_c2h_tvalid && m_axis_c2h_tready;
        if (out_fire && exp_q.size() != 0) begin
            eb       = exp_q.pop_front();
            exp_last = eb.last || (exp_pkt_beats == PB - 1);
            chk("out_tdata", m_axis_c2h_tdata, eb.data);
            chk("out_tkeep", m_axis_c2h_tkeep, eb.keep);
            chk("out_tlast", m_axis_c2h_tlast, exp_last);
            out_idx++;
            if (exp_last) begin
                last_pos.push_back(out_idx);
                exp_pkt_beats = 0;
                exp_pkt_count = exp_pkt_count + 16'd1;
            end else begin
                exp_pkt_beats++;
            end
        end
        if (in_fire) begin
            exp_q.push_back(src_q.pop_front());
            accepted++;
        end
        stall_prev = m_axis_c2h_tvalid && !m_axis_c2h_tready;
        held       = '{last: m_axis_c2h_tlast, keep: m_axis_c2h_tkeep, data: m_axis_c2h_tdata};
        @(posedge user_clk);
        @(negedge user_clk);
        chk("pkt_count", pkt_count, exp_pkt_count);
        if (!s_axis_tvalid || in_fire) begin
            if (src_q.size() != 0 && int'($urandom_range(99)) < valid_pct) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0].data;
                s_axis_tkeep  = src_q[0].keep;
                s_axis_tlast  = src_q[0].last;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
        m_axis_c2h_tready = int'($urandom_range(99)) < ready_pct;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_in_time", n < max_cyc, 1);
    endtask

    initial begin
        int n;
        int exp_lp[4];
        exp_lp = '{32, 64, 96, 113};
        user_rst = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        m_axis_c2h_tready = 1'b0;
        irq_ack = 1'b0;
        #2;
        do_reset();

        // 113 beats, tlast only on the final one: split into 32/32/32/17.
        valid_pct = 100; ready_pct = 100;
        add_beats(113, 0, 1'b1, 0);
        drain(400);
        chk("split_n_pkts", last_pos.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < last_pos.size()) chk("split_last_pos", last_pos[i], exp_lp[i]);
        end
        chk("split_pkt_count", pkt_count, 4);

        // Downstream stalled: exactly DEPTH beats accepted, then drained in order.
        do_reset();
        ready_pct = 0; m_axis_c2h_tready = 1'b0;
        add_beats(20, 0, 1'b1, 0);
        repeat (25) cycle();
        chk("full_accepted", accepted, DEPTH);
        chk("full_tready_low", s_axis_tready, 0);
        ready_pct = 100;
        drain(200);

        // Short packet ends on upstream tlast; interrupt follows quickly; counter restarts.
        do_reset();
        add_beats(5, 0, 1'b1, 0);
        n = 0;
        while (out_idx < 5 && n < 50) begin cycle(); n++; end
        chk("short_pkt_beats", out_idx, 5);
        n = 0;
        while (!irq_req && n < 2) begin cycle(); n++; end
        chk("irq_after_pkt", irq_req, 1);
        add_beats(32, 0, 1'b0, 0);
        drain(200);
        chk("short_n_pkts", last_pos.size(), 2);
        if (last_pos.size() == 2) chk("restart_full_pkt", last_pos[1], 37);

        // Three completions before any ack: three separate interrupt requests.
        do_reset();
        add_beats(9, 3, 1'b0, 0);
        drain(100);
        repeat (3) cycle();
        chk("irq_held", irq_req, 1);
        for (int k = 0; k < 3; k++) begin
            irq_ack = 1'b1;
            cycle();
            irq_ack = 1'b0;
            chk("irq_ack_low", irq_req, 0);
            n = 0;
            while (!irq_req && n < 4) begin cycle(); n++; end
            if (k < 2) chk("irq_reassert", irq_req, 1);
            else       chk("irq_quiet", irq_req, 0);
        end
        irq_ack = 1'b1;
        cycle();
        irq_ack = 1'b0;
        chk("irq_stray_ack", irq_req, 0);
        add_beats(1, 0, 1'b1, 0);
        drain(20);
        cycle();
        chk("irq_after_stray_ack", irq_req, 1);

        // Reset with 10 beats emitted and 6 buffered mid-packet.
        do_reset();
        ready_pct = 0; m_axis_c2h_tready = 1'b0;
        add_beats(16, 0, 1'b0, 0);
        repeat (20) cycle();
        ready_pct = 100;
        n = 0;
        while (out_idx < 10 && n < 50) begin cycle(); n++; end
        ready_pct = 0; m_axis_c2h_tready = 1'b0;
        chk("mid_emitted", out_idx, 10);
        chk("mid_buffered_valid", m_axis_c2h_tvalid, 1);
        #2;
        do_reset();
        ready_pct = 100;
        add_beats(32, 0, 1'b0, 0);
        drain(200);
        chk("post_rst_n_pkts", last_pos.size(), 1);
        if (last_pos.size() == 1) chk("post_rst_pkt_len", last_pos[0], 32);
        chk("post_rst_pkt_count", pkt_count, 1);

        // Random handshakes and random packet boundaries.
        do_reset();
        valid_pct = 70; ready_pct = 60;
        add_beats(200, 0, 1'b0, 10);
        drain(3000);

        // Counter wrap: 65535 single-beat packets, then one more.
        do_reset();
        valid_pct = 100; ready_pct = 100;
        add_beats(65535, 1, 1'b0, 0);
        drain(70000);
        chk("pkt_count_max", pkt_count, 16'hFFFF);
        add_beats(1, 1, 1'b0, 0);
        drain(20);
        chk("pkt_count_wrap", pkt_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
